ins_encoder_fifo: RTL and testbench
===================================

// Module: ins_encoder_fifo
// PURPOSE
//  Inverse of the pipeline decode stage: packs decoded control fields (instruction class, FUN3,
//  ALT/M-ext flags, register indices, immediate, AMO op) into 32-bit RV32IMA instruction words.
//  Words are buffered in a FIFO and streamed to the fetch/debug injection path over valid/ready.
//  Also used by the bench to generate decode stimulus.
// PARAMETERS
//  DEPTH      4   output FIFO entries; power of 2, >=2
//  CNT_W      3   width of COUNT; must equal clog2(DEPTH)+1
// PORTS
//  CLK          in   1   single clock, all state on rising edge
//  RST_N        in   1   reset, asynchronous, active-low
//  REQ_VALID    in   1   encode request present
//  REQ_READY    out  1   request accepted on CLK edge when VALID&READY
//  REQ_CLASS    in   4   0 lui,1 auipc,2 jal,3 jalr,4 branch,5 load,6 store,7 iop,8 rop,9 system,10 amo,11 fence
//  REQ_FUN3     in   3   funct3
//  REQ_ALT      in   1   funct7[5]: sub/sra/srai
//  REQ_MEXT     in   1   rop only: funct7=7'b0000001
//  REQ_RD       in   5   rd
//  REQ_RS1      in   5   rs1, or CSR zimm
//  REQ_RS2      in   5   rs2
//  REQ_IMM      in   32  sign-extended byte immediate; CSR/priv code in [11:0]
//  REQ_AMO      in   5   amo funct5
//  REQ_AQRL     in   2   amo aq,rl
//  INS_VALID    out  1   FIFO head valid
//  INS_READY    in   1   consumer takes head on CLK edge when VALID&READY
//  INS_DATA     out  32  head instruction word
//  INS_ILLEGAL  out  1   head word failed encode checks
//  COUNT        out  CNT_W  FIFO occupancy
// BEHAVIOUR
//  Reset (RST_N low, async): FIFO pointers, COUNT and stage-valid = 0; INS_VALID=0; INS_DATA=0;
//    INS_ILLEGAL=0; REQ_READY=0 while RST_N low. In-flight request and FIFO contents are discarded.
//  Pipeline: 2-stage. Stage 1 registers the encoded word and illegal flag on accept.
//    Stage 2 writes the next edge into the FIFO. Accept at edge N -> INS_VALID high after edge N+1.
//  REQ_READY = (COUNT + stage_valid) < DEPTH (combinational). The stage never stalls.
//  Opcodes:
//    lui 0110111, auipc 0010111, jal 1101111, jalr 1100111, branch 1100011, load 0000011,
//    store 0100011, iop 0010011, rop 0110011, system 1110011, amo 0101111, fence 0001111.
//  Formats:
//    U: IMM[31:12]
//    J: IMM[20|10:1|11|19:12]
//    I (jalr/load/iop/system): IMM[11:0]
//    S: IMM[11:5] at [31:25], IMM[4:0] at [11:7]
//    B: IMM[12|10:5] at [31:25], IMM[4:1|11] at [11:7]
//  rop funct7 = MEXT ? 0000001 : {1'b0,ALT,5'b0}.
//  iop shifts (FUN3 001/101): [31:25] = {1'b0,ALT,5'b0}, [24:20] = IMM[4:0].
//  amo: [31:27] = AMO, [26:25] = AQRL, FUN3 forced 010.
//  fence: FUN3 = REQ_FUN3, IMM[11:0] at [31:20], rd/rs1 from request.
//  system: FUN3=000 puts IMM[11:0] at [31:20] (ecall 000, ebreak 001, mret 302, wfi 105),
//    with rd=rs1=0. CSR FUN3 puts csr address IMM[11:0] at [31:20] and RS1 as rs1/zimm.
//  Illegal, word forced to 32'h0 and INS_ILLEGAL=1:
//    - CLASS > 11
//    - I/S imm not representable in signed 12 bits
//    - B imm not in signed 13 bits, or IMM[0]=1
//    - J imm not in signed 21 bits, or IMM[0]=1
//    - U with IMM[11:0] != 0
//    - shift with IMM[31:5] != 0
//    - MEXT with class != rop
//    - system FUN3 = 100
//  FIFO: write and read pointers wrap modulo DEPTH. Push and pop in the same cycle leave COUNT
//    unchanged. A pop when COUNT=0 is ignored. INS_DATA/INS_ILLEGAL hold their value while
//    INS_READY is low. A push with COUNT=DEPTH cannot occur by construction; the bench asserts this.
// TESTING
//  1. lui rd=5 imm=0x12345000 -> INS_DATA=32'h123452B7, ILLEGAL=0, INS_VALID two edges after accept.
//  2. iop addi rd=1 rs1=0 imm=-1 -> 32'hFFF00093; rop ALT=1 rd=3 rs1=1 rs2=2 -> 32'h402081B3 (sub).
//  3. branch FUN3=000 imm=0x7 -> 32'h0 with ILLEGAL=1. The next legal request still encodes correctly.
//  4. INS_READY=0, stream requests -> exactly DEPTH accepted, then REQ_READY=0 and COUNT=4.
//     Raise INS_READY -> words drain in order; REQ_READY reasserts the cycle after the first pop.
//  5. Continuous VALID with INS_READY=1 -> one word per cycle, COUNT stable; pointer wrap exercised >3*DEPTH words.
//  6. Assert RST_N low mid-stream with COUNT=3 -> INS_VALID/COUNT=0 immediately (async), no stale word after release.

Source files
------------

// File: rtl/ins_encoder_fifo.sv
// RV32IMA instruction encoder: packs decoded control fields into 32-bit words,
// registers them in one stage and buffers them in a small FIFO with valid/ready on both sides.
module ins_encoder_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_class,
  input  logic [2:0]       req_fun3,
  input  logic             req_alt,
  input  logic             req_mext,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [31:0]      req_imm,
  input  logic [4:0]       req_amo,
  input  logic [1:0]       req_aqrl,
  output logic             ins_valid,
  input  logic             ins_ready,
  output logic [31:0]      ins_data,
  output logic             ins_illegal,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   DEPTH_V = (CNT_W + 1)'(DEPTH);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IOP    = 7'b0010011;
  localparam logic [6:0] OP_ROP    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  // Returns {illegal, word}; an illegal request always yields an all-zero word.
  function automatic logic [32:0] encode(
    input logic [3:0]  cls,
    input logic [2:0]  fun3,
    input logic        alt,
    input logic        mext,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm,
    input logic [4:0]  amo,
    input logic [1:0]  aqrl
  );
    logic [31:0] w;
    logic        bad;
    logic [6:0]  f7;
    logic        is_shift;
    logic        s12;
    logic        s13;
    logic        s21;
    w        = 32'h0;
    bad      = 1'b0;
    f7       = {1'b0, alt, 5'b00000};
    is_shift = (fun3 == 3'b001) || (fun3 == 3'b101);
    s12      = (&imm[31:11]) || ~(|imm[31:11]);
    s13      = (&imm[31:12]) || ~(|imm[31:12]);
    s21      = (&imm[31:20]) || ~(|imm[31:20]);
    case (cls)
      4'd0: begin
        w   = {imm[31:12], rd, OP_LUI};
        bad = (imm[11:0] != 12'h000);
      end
      4'd1: begin
        w   = {imm[31:12], rd, OP_AUIPC};
        bad = (imm[11:0] != 12'h000);
      end
      4'd2: begin
        w   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        bad = !s21 || imm[0];
      end
      4'd3: begin
        w   = {imm[11:0], rs1, fun3, rd, OP_JALR};
        bad = !s12;
      end
      4'd4: begin
        w   = {imm[12], imm[10:5], rs2, rs1, fun3, imm[4:1], imm[11], OP_BRANCH};
        bad = !s13 || imm[0];
      end
      4'd5: begin
        w   = {imm[11:0], rs1, fun3, rd, OP_LOAD};
        bad = !s12;
      end
      4'd6: begin
        w   = {imm[11:5], rs2, rs1, fun3, imm[4:0], OP_STORE};
        bad = !s12;
      end
      4'd7: begin
        if (is_shift) begin
          w   = {f7, imm[4:0], rs1, fun3, rd, OP_IOP};
          bad = (imm[31:5] != 27'h0);
        end else begin
          w   = {imm[11:0], rs1, fun3, rd, OP_IOP};
          bad = !s12;
        end
      end
      4'd8: begin
        w   = {(mext ? 7'b0000001 : f7), rs2, rs1, fun3, rd, OP_ROP};
        bad = 1'b0;
      end
      4'd9: begin
        // Privileged ops (funct3 000) carry only the code in the immediate field.
        if (fun3 == 3'b000) begin
          w = {imm[11:0], 5'd0, 3'b000, 5'd0, OP_SYSTEM};
        end else begin
          w = {imm[11:0], rs1, fun3, rd, OP_SYSTEM};
        end
        bad = !s12 || (fun3 == 3'b100);
      end
      4'd10: begin
        w   = {amo, aqrl, rs2, rs1, 3'b010, rd, OP_AMO};
        bad = 1'b0;
      end
      4'd11: begin
        w   = {imm[11:0], rs1, fun3, rd, OP_FENCE};
        bad = 1'b0;
      end
      default: begin
        w   = 32'h0;
        bad = 1'b1;
      end
    endcase
    if (mext && (cls != 4'd8)) begin
      bad = 1'b1;
    end else begin
      bad = bad;
    end
    if (bad) begin
      w = 32'h0;
    end else begin
      w = w;
    end
    return {bad, w};
  endfunction

  logic [32:0]      enc;
  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   occupancy;
  logic             stage_valid;
  logic [31:0]      stage_word;
  logic             stage_ill;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      data_mem [DEPTH];
  logic             ill_mem  [DEPTH];

  // Encoder and handshake decode.
  always_comb begin
    enc       = encode(req_class, req_fun3, req_alt, req_mext, req_rd, req_rs1, req_rs2,
                       req_imm, req_amo, req_aqrl);
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, stage_valid};
    req_ready = rst_n && (occupancy < DEPTH_V);
    accept    = req_valid && req_ready;
    ins_valid = (count != {CNT_W{1'b0}});
    push      = stage_valid;
    pop       = ins_valid && ins_ready;
    ins_data    = data_mem[rd_ptr];
    ins_illegal = ill_mem[rd_ptr];
  end

  // Encode stage register; never stalls because req_ready reserves a FIFO slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_word  <= 32'h0;
      stage_ill   <= 1'b0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_word <= enc[31:0];
        stage_ill  <= enc[32];
      end else begin
        stage_word <= stage_word;
        stage_ill  <= stage_ill;
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= 32'h0;
        ill_mem[i]  <= 1'b0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= stage_word;
        ill_mem[wr_ptr]  <= stage_ill;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end else begin
        wr_ptr <= wr_ptr;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        rd_ptr <= rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_encoder_fifo.sv
// Directed bench for ins_encoder_fifo: table of encode vectors with hand-computed words,
// plus sequences for FIFO fill/drain, streaming with pointer wrap, and async reset.
module tb_ins_encoder_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_class;
  logic [2:0]  req_fun3;
  logic        req_alt;
  logic        req_mext;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic [4:0]  req_amo;
  logic [1:0]  req_aqrl;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic        ins_illegal;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  int overflow_seen = 0;

  ins_encoder_fifo #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_class(req_class), .req_fun3(req_fun3), .req_alt(req_alt), .req_mext(req_mext),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .req_amo(req_amo), .req_aqrl(req_aqrl), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .ins_illegal(ins_illegal), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cls;
    logic [2:0]  fun3;
    logic        alt;
    logic        mext;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [4:0]  amo;
    logic [1:0]  aqrl;
    logic [31:0] exp_word;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] c, input logic [2:0] f3, input logic alt,
                              input logic mx, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic [4:0] amo, input logic [1:0] aqrl,
                              input logic [31:0] w, input logic ill);
    vec_t v;
    v.cls = c; v.fun3 = f3; v.alt = alt; v.mext = mx; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.amo = amo; v.aqrl = aqrl; v.exp_word = w; v.exp_ill = ill;
    return v;
  endfunction

  function automatic logic [31:0] lui_word(input int n);
    return (32'(n) << 12) | (32'(n) << 7) | 32'h00000037;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_class = v.cls; req_fun3 = v.fun3; req_alt = v.alt; req_mext = v.mext;
    req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2; req_imm = v.imm;
    req_amo = v.amo; req_aqrl = v.aqrl;
  endtask

  task automatic drive_lui(input int n);
    drive(mk(4'd0, 3'd0, 1'b0, 1'b0, 5'(n), 5'd0, 5'd0, 32'(n) << 12, 5'd0, 2'd0, 32'h0, 1'b0));
  endtask

  // One request through the pipe with the consumer always ready.
  task automatic apply_vec(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    drive(v);
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL vec%0d_accept_timeout: actual req_ready=0 required 1", idx);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d_valid_early", idx), {31'h0, ins_valid}, 32'h0);
    @(negedge clk);
    chk($sformatf("vec%0d_valid", idx), {31'h0, ins_valid}, 32'h1);
    chk($sformatf("vec%0d_word", idx), ins_data, v.exp_word);
    chk($sformatf("vec%0d_illegal", idx), {31'h0, ins_illegal}, {31'h0, v.exp_ill});
    @(negedge clk);
  endtask

  // Pushing into a full FIFO must never happen.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dut.stage_valid === 1'b1 && count == 3'd4) overflow_seen++;
  end

  initial begin
    int acc;
    int recv;
    int hi_cnt;
    logic [31:0] q[$];

    // class, f3, alt, mext, rd, rs1, rs2, imm, amo, aqrl, word, illegal
    vecs.push_back(mk(4'd0,  3'd0, 1'b0, 1'b0, 5'd5,  5'd0,  5'd0,  32'h12345000, 5'd0, 2'd0, 32'h123452B7, 1'b0));
    vecs.push_back(mk(4'd7,  3'd0, 1'b0, 1'b0, 5'd1,  5'd0,  5'd0,  32'hFFFFFFFF, 5'd0, 2'd0, 32'hFFF00093, 1'b0));
    vecs.push_back(mk(4'd8,  3'd0, 1'b1, 1'b0, 5'd3,  5'd1,  5'd2,  32'h00000000, 5'd0, 2'd0, 32'h402081B3, 1'b0));
    vecs.push_back(mk(4'd4,  3'd0, 1'b0, 1'b0, 5'd0,  5'd1,  5'd2,  32'h00000007, 5'd0, 2'd0, 32'h00000000, 1'b1));
    vecs.push_back(mk(4'd4,  3'd0, 1'b0, 1'b0, 5'd0,  5'd1,  5'd2,  32'h00000008, 5'd0, 2'd0, 32'h00208463, 1'b0));
    vecs.push_back(mk(4'd2,  3'd0, 1'b0, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00000800, 5'd0, 2'd0, 32'h001000EF, 1'b0));
    vecs.push_back(mk(4'd6,  3'd2, 1'b0, 1'b0, 5'd0,  5'd2,  5'd5,  32'h0000000C, 5'd0, 2'd0, 32'h00512623, 1'b0));
    vecs.push_back(mk(4'd7,  3'd5, 1'b1, 1'b0, 5'd1,  5'd1,  5'd0,  32'h00000003, 5'd0, 2'd0, 32'h4030D093, 1'b0));
    vecs.push_back(mk(4'd8,  3'd0, 1'b0, 1'b1, 5'd10, 5'd11, 5'd12, 32'h00000000, 5'd0, 2'd0, 32'h02C58533, 1'b0));
    vecs.push_back(mk(4'd9,  3'd0, 1'b0, 1'b0, 5'd5,  5'd6,  5'd0,  32'h00000302, 5'd0, 2'd0, 32'h30200073, 1'b0));
    vecs.push_back(mk(4'd9,  3'd1, 1'b0, 1'b0, 5'd1,  5'd2,  5'd0,  32'h00000300, 5'd0, 2'd0, 32'h300110F3, 1'b0));
    vecs.push_back(mk(4'd10, 3'd0, 1'b0, 1'b0, 5'd1,  5'd2,  5'd3,  32'h00000000, 5'd0, 2'd3, 32'h063120AF, 1'b0));
    vecs.push_back(mk(4'd11, 3'd0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h000000FF, 5'd0, 2'd0, 32'h0FF0000F, 1'b0));
    vecs.push_back(mk(4'd1,  3'd0, 1'b0, 1'b0, 5'd2,  5'd0,  5'd0,  32'hFFFFF000, 5'd0, 2'd0, 32'hFFFFF117, 1'b0));
    vecs.push_back(mk(4'd3,  3'd0, 1'b0, 1'b0, 5'd0,  5'd1,  5'd0,  32'h00000000, 5'd0, 2'd0, 32'h00008067, 1'b0));
    vecs.push_back(mk(4'd5,  3'd2, 1'b0, 1'b0, 5'd5,  5'd2,  5'd0,  32'hFFFFFFFC, 5'd0, 2'd0, 32'hFFC12283, 1'b0));
    vecs.push_back(mk(4'd12, 3'd0, 1'b0, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00000000, 5'd0, 2'd0, 32'h00000000, 1'b1));
    vecs.push_back(mk(4'd0,  3'd0, 1'b0, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00000123, 5'd0, 2'd0, 32'h00000000, 1'b1));
    vecs.push_back(mk(4'd7,  3'd1, 1'b0, 1'b0, 5'd1,  5'd1,  5'd0,  32'h00000020, 5'd0, 2'd0, 32'h00000000, 1'b1));
    vecs.push_back(mk(4'd7,  3'd0, 1'b0, 1'b1, 5'd1,  5'd1,  5'd0,  32'h00000000, 5'd0, 2'd0, 32'h00000000, 1'b1));
    vecs.push_back(mk(4'd9,  3'd4, 1'b0, 1'b0, 5'd1,  5'd1,  5'd0,  32'h00000300, 5'd0, 2'd0, 32'h00000000, 1'b1));
    vecs.push_back(mk(4'd7,  3'd0, 1'b0, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00000800, 5'd0, 2'd0, 32'h00000000, 1'b1));
    vecs.push_back(mk(4'd2,  3'd0, 1'b0, 1'b0, 5'd1,  5'd0,  5'd0,  32'h00000003, 5'd0, 2'd0, 32'h00000000, 1'b1));
    vecs.push_back(mk(4'd4,  3'd0, 1'b0, 1'b0, 5'd0,  5'd1,  5'd2,  32'h00001000, 5'd0, 2'd0, 32'h00000000, 1'b1));
    vecs.push_back(mk(4'd7,  3'd0, 1'b0, 1'b0, 5'd1,  5'd0,  5'd0,  32'hFFFFF800, 5'd0, 2'd0, 32'h80000093, 1'b0));
    vecs.push_back(mk(4'd4,  3'd0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'hFFFFF000, 5'd0, 2'd0, 32'h80000063, 1'b0));
    vecs.push_back(mk(4'd9,  3'd0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'h00000001, 5'd0, 2'd0, 32'h00100073, 1'b0));

    rst_n = 1'b0;
    req_valid = 1'b0;
    ins_ready = 1'b1;
    drive_lui(0);
    #3;
    chk("rst_ins_valid", {31'h0, ins_valid}, 32'h0);
    chk("rst_count", {29'h0, count}, 32'h0);
    chk("rst_ins_data", ins_data, 32'h0);
    chk("rst_ins_illegal", {31'h0, ins_illegal}, 32'h0);
    chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Fill with the consumer stalled, then drain in order.
    ins_ready = 1'b0;
    acc = 0;
    q.delete();
    @(negedge clk);
    req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      drive_lui(acc + 1);
      if (req_ready) begin
        q.push_back(lui_word(acc + 1));
        acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("fill_accepted", 32'(acc), 32'd4);
    chk("fill_req_ready", {31'h0, req_ready}, 32'h0);
    chk("fill_count", {29'h0, count}, 32'h4);
    chk("fill_head", ins_data, lui_word(1));
    @(negedge clk);
    chk("hold_head", ins_data, lui_word(1));
    ins_ready = 1'b1;
    @(negedge clk);
    chk("drain_req_ready", {31'h0, req_ready}, 32'h1);
    chk("drain_count", {29'h0, count}, 32'h3);
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("drain_word%0d", k), ins_data, lui_word(k + 1));
      @(negedge clk);
    end
    chk("drain_empty", {29'h0, count}, 32'h0);

    // Continuous streaming, wraps pointers several times.
    q.delete();
    acc = 0;
    recv = 0;
    for (int it = 0; it < 60 && recv < 16; it++) begin
      if (ins_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: actual %h required none", ins_data);
        end else begin
          chk($sformatf("stream_word%0d", recv), ins_data, q.pop_front());
        end
        recv++;
      end
      if (it >= 3 && acc < 16) begin
        chk($sformatf("stream_count%0d", it), {29'h0, count}, 32'h1);
      end
      req_valid = (acc < 16);
      drive_lui(acc + 1);
      if (req_valid && req_ready) begin
        q.push_back(lui_word(acc + 1));
        acc++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("stream_received", 32'(recv), 32'd16);

    // Async reset mid-stream with three words queued and one in the stage.
    ins_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1;
    for (int c = 0; c < 10 && acc < 4; c++) begin
      drive_lui(acc + 20);
      if (req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("pre_rst_count", {29'h0, count}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ins_valid", {31'h0, ins_valid}, 32'h0);
    chk("async_count", {29'h0, count}, 32'h0);
    chk("async_req_ready", {31'h0, req_ready}, 32'h0);
    chk("async_ins_data", ins_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ins_ready = 1'b1;
    hi_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ins_valid) hi_cnt++;
    end
    chk("no_stale_word", 32'(hi_cnt), 32'd0);
    chk("no_overflow_push", 32'(overflow_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
